// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the ID-stage controller: opcodes, functs, ALUFun codes,
// PCSrc selects and the layout of the EX-stage control bundle.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BLTZ  = 6'h01;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_BLEZ  = 6'h06;
  localparam logic [5:0] OP_BGTZ  = 6'h07;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  localparam logic [5:0] ALU_ADD = 6'b000000;
  localparam logic [5:0] ALU_SUB = 6'b000001;
  localparam logic [5:0] ALU_AND = 6'b011000;
  localparam logic [5:0] ALU_OR  = 6'b011110;
  localparam logic [5:0] ALU_XOR = 6'b010110;
  localparam logic [5:0] ALU_NOR = 6'b010001;
  localparam logic [5:0] ALU_SLL = 6'b100000;
  localparam logic [5:0] ALU_SRL = 6'b100001;
  localparam logic [5:0] ALU_SRA = 6'b100011;
  localparam logic [5:0] ALU_EQ  = 6'b110011;
  localparam logic [5:0] ALU_NEQ = 6'b110001;
  localparam logic [5:0] ALU_LT  = 6'b110101;
  localparam logic [5:0] ALU_LEZ = 6'b111101;
  localparam logic [5:0] ALU_LTZ = 6'b111011;
  localparam logic [5:0] ALU_GTZ = 6'b111111;

  typedef enum logic [2:0] {
    PC_SEQ    = 3'b000,
    PC_BRANCH = 3'b001,
    PC_JUMP   = 3'b010,
    PC_JREG   = 3'b011,
    PC_IRQ    = 3'b100,
    PC_EXC    = 3'b101
  } pcsrc_e;

  // Bit offsets of the fields inside the 21-bit ex_ctrl bundle (bit 20 reserved, always 0).
  localparam int EXF_VALID     = 19;
  localparam int EXF_REGWRITE  = 18;
  localparam int EXF_REGDST    = 16;
  localparam int EXF_MEMREAD   = 15;
  localparam int EXF_MEMWRITE  = 14;
  localparam int EXF_MEMTOREG  = 12;
  localparam int EXF_ALUSRC1   = 11;
  localparam int EXF_ALUSRC2   = 10;
  localparam int EXF_EXTOP     = 9;
  localparam int EXF_LUOP      = 8;
  localparam int EXF_SIGN      = 7;
  localparam int EXF_ALUFUN    = 1;
  localparam int EXF_BRANCH    = 0;

  typedef struct packed {
    logic       rsvd;
    logic       valid;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] mem_to_reg;
    logic       alu_src1;
    logic       alu_src2;
    logic       ext_op;
    logic       lu_op;
    logic       sign;
    logic [5:0] alu_fun;
    logic       branch;
  } ex_ctrl_t;

  // Trap entry: write the interrupted PC into $26 (RegDst=11, MemtoReg=11).
  function automatic ex_ctrl_t trap_ctrl();
    ex_ctrl_t c;
    c            = '0;
    c.valid      = 1'b1;
    c.reg_write  = 1'b1;
    c.reg_dst    = 2'b11;
    c.mem_to_reg = 2'b11;
    return c;
  endfunction

  function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      idx = idx | (oh[i] ? 3'(i) : 3'd0);
    end
    return idx;
  endfunction

endpackage

// File: rtl/irq_arbiter.sv
// Interrupt front end: rising-edge detect, sticky pending bits, and a
// lowest-index-wins select gated by the caller's take enable.
module irq_arbiter
  import mips_ctrl_pkg::*;
#(
  parameter int N_IRQ = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] i_irq,
  input  logic [N_IRQ-1:0] i_mask,
  input  logic             i_take_en,
  output logic [N_IRQ-1:0] o_ack,
  output logic             o_take,
  output logic [2:0]       o_idx
);

  logic [N_IRQ-1:0] r_prev;
  logic [N_IRQ-1:0] r_pending;
  logic [N_IRQ-1:0] w_rise;
  logic [N_IRQ-1:0] w_elig;
  logic [N_IRQ-1:0] w_sel;
  logic [7:0]       w_sel_wide;

  assign w_rise = i_irq & ~r_prev;
  assign w_elig = r_pending & i_mask;
  // x & -x isolates the lowest set bit.
  assign w_sel  = w_elig & (-w_elig);
  assign o_ack  = i_take_en ? w_sel : '0;
  assign o_take = |o_ack;
  assign o_idx  = onehot_to_idx(w_sel_wide);

  // Zero-extend the one-hot select to the fixed 8-channel index helper width.
  always_comb begin
    w_sel_wide             = 8'h00;
    w_sel_wide[N_IRQ-1:0]  = w_sel;
  end

  // Edge history and pending bits; a fresh edge wins over the clear from a take.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_prev    <= '0;
      r_pending <= '0;
    end else begin
      r_prev    <= i_irq;
      r_pending <= (r_pending & ~o_ack) | w_rise;
    end
  end

endmodule

// File: rtl/id_decode_ctrl.sv
// ID-stage controller: decodes the instruction into the registered EX control
// bundle and selects the next-PC source among IRQ, exception, branch and jumps.
module id_decode_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int N_IRQ  = 4,
  parameter int EN_EXC = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       OpCode,
  input  logic [5:0]       Funct,
  input  logic             PC_31,
  input  logic             PC_id_31,
  input  logic             BranchEn,
  input  logic             Stall,
  input  logic             Flush,
  input  logic [N_IRQ-1:0] IRQ,
  input  logic [N_IRQ-1:0] IRQMask,
  output logic [2:0]       PCSrc,
  output logic             IF_Flush,
  output logic [20:0]      ex_ctrl,
  output logic [N_IRQ-1:0] irq_ack,
  output logic [2:0]       irq_cause,
  output logic             exc_pending
);

  ex_ctrl_t w_dec;
  logic     w_undef;
  logic     w_is_j;
  logic     w_is_jr;
  logic     w_take_en;
  logic     w_take;
  logic [2:0] w_idx;
  logic     w_exc;
  logic     w_issue;
  pcsrc_e   w_pcsrc;
  ex_ctrl_t r_ex_ctrl;
  logic [2:0] r_irq_cause;
  logic     r_exc_pending;

  assign w_take_en = reset & ~PC_31 & ~PC_id_31 & ~Stall;
  assign w_issue   = ~Stall & ~Flush;
  assign w_exc     = (EN_EXC != 0) & reset & w_undef & ~w_take & w_issue;

  irq_arbiter #(.N_IRQ(N_IRQ)) u_irq_arbiter (
    .clk       (clk),
    .reset     (reset),
    .i_irq     (IRQ),
    .i_mask    (IRQMask),
    .i_take_en (w_take_en),
    .o_ack     (irq_ack),
    .o_take    (w_take),
    .o_idx     (w_idx)
  );

  // Instruction decode; anything unrecognised falls back to the NOP bundle.
  always_comb begin
    w_dec         = '0;
    w_dec.valid   = 1'b1;
    w_dec.sign    = 1'b1;
    w_dec.alu_fun = ALU_ADD;
    w_undef       = 1'b0;
    w_is_j        = 1'b0;
    w_is_jr       = 1'b0;
    case (OpCode)
      OP_RTYPE: begin
        w_dec.reg_write = 1'b1;
        case (Funct)
          FN_ADD:  w_dec.alu_fun = ALU_ADD;
          FN_ADDU: w_dec.sign    = 1'b0;
          FN_SUB:  w_dec.alu_fun = ALU_SUB;
          FN_SUBU: begin w_dec.alu_fun = ALU_SUB; w_dec.sign = 1'b0; end
          FN_AND:  w_dec.alu_fun = ALU_AND;
          FN_OR:   w_dec.alu_fun = ALU_OR;
          FN_XOR:  w_dec.alu_fun = ALU_XOR;
          FN_NOR:  w_dec.alu_fun = ALU_NOR;
          FN_SLT:  w_dec.alu_fun = ALU_LT;
          FN_SLL:  begin w_dec.alu_fun = ALU_SLL; w_dec.alu_src1 = 1'b1; end
          FN_SRL:  begin w_dec.alu_fun = ALU_SRL; w_dec.alu_src1 = 1'b1; end
          FN_SRA:  begin w_dec.alu_fun = ALU_SRA; w_dec.alu_src1 = 1'b1; end
          FN_JR:   begin w_dec.reg_write = 1'b0; w_is_jr = 1'b1; end
          FN_JALR: begin w_dec.mem_to_reg = 2'b10; w_is_jr = 1'b1; end
          default: begin w_dec.reg_write = 1'b0; w_undef = 1'b1; end
        endcase
      end
      OP_LW: begin
        w_dec.reg_write  = 1'b1;
        w_dec.reg_dst    = 2'b01;
        w_dec.mem_read   = 1'b1;
        w_dec.mem_to_reg = 2'b01;
        w_dec.alu_src2   = 1'b1;
        w_dec.ext_op     = 1'b1;
      end
      OP_SW: begin
        w_dec.mem_write = 1'b1;
        w_dec.alu_src2  = 1'b1;
        w_dec.ext_op    = 1'b1;
      end
      OP_LUI: begin
        w_dec.reg_write = 1'b1;
        w_dec.reg_dst   = 2'b01;
        w_dec.alu_src2  = 1'b1;
        w_dec.lu_op     = 1'b1;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
        w_dec.reg_write = 1'b1;
        w_dec.reg_dst   = 2'b01;
        w_dec.alu_src2  = 1'b1;
        w_dec.ext_op    = 1'b1;
        w_dec.alu_fun   = ((OpCode == OP_SLTI) || (OpCode == OP_SLTIU)) ? ALU_LT : ALU_ADD;
        w_dec.sign      = (OpCode == OP_ADDI) || (OpCode == OP_SLTI);
      end
      OP_ANDI: begin
        w_dec.reg_write = 1'b1;
        w_dec.reg_dst   = 2'b01;
        w_dec.alu_src2  = 1'b1;
        w_dec.alu_fun   = ALU_AND;
      end
      OP_BEQ:  begin w_dec.branch = 1'b1; w_dec.ext_op = 1'b1; w_dec.alu_fun = ALU_EQ;  end
      OP_BNE:  begin w_dec.branch = 1'b1; w_dec.ext_op = 1'b1; w_dec.alu_fun = ALU_NEQ; end
      OP_BLEZ: begin w_dec.branch = 1'b1; w_dec.ext_op = 1'b1; w_dec.alu_fun = ALU_LEZ; end
      OP_BGTZ: begin w_dec.branch = 1'b1; w_dec.ext_op = 1'b1; w_dec.alu_fun = ALU_GTZ; end
      OP_BLTZ: begin w_dec.branch = 1'b1; w_dec.ext_op = 1'b1; w_dec.alu_fun = ALU_LTZ; end
      OP_J:    w_is_j = 1'b1;
      OP_JAL: begin
        w_is_j           = 1'b1;
        w_dec.reg_write  = 1'b1;
        w_dec.reg_dst    = 2'b10;
        w_dec.mem_to_reg = 2'b10;
      end
      default: w_undef = 1'b1;
    endcase
  end

  // Next-PC select; jumps from a stalled or squashed ID slot do not redirect.
  always_comb begin
    w_pcsrc = PC_SEQ;
    if (!reset) begin
      w_pcsrc = PC_SEQ;
    end else if (w_take) begin
      w_pcsrc = PC_IRQ;
    end else if (w_exc) begin
      w_pcsrc = PC_EXC;
    end else if (BranchEn) begin
      w_pcsrc = PC_BRANCH;
    end else if (w_is_j && w_issue) begin
      w_pcsrc = PC_JUMP;
    end else if (w_is_jr && w_issue) begin
      w_pcsrc = PC_JREG;
    end else begin
      w_pcsrc = PC_SEQ;
    end
  end

  assign PCSrc       = w_pcsrc;
  assign IF_Flush    = (w_pcsrc != PC_SEQ);
  assign ex_ctrl     = r_ex_ctrl;
  assign irq_cause   = r_irq_cause;
  assign exc_pending = r_exc_pending;

  // EX control bundle, trap cause and exception flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ex_ctrl     <= '0;
      r_irq_cause   <= 3'd0;
      r_exc_pending <= 1'b0;
    end else begin
      if (w_take) begin
        r_ex_ctrl   <= trap_ctrl();
        r_irq_cause <= w_idx;
      end else if (!w_issue) begin
        r_ex_ctrl   <= '0;
      end else if (w_exc) begin
        r_ex_ctrl   <= trap_ctrl();
      end else begin
        r_ex_ctrl   <= w_dec;
      end

      if (w_take) begin
        r_exc_pending <= 1'b0;
      end else if (w_exc) begin
        r_exc_pending <= 1'b1;
      end else if (w_issue) begin
        r_exc_pending <= 1'b0;
      end else begin
        r_exc_pending <= r_exc_pending;
      end
    end
  end

endmodule

// File: tb/tb_id_decode_ctrl.sv
// Directed bench for id_decode_ctrl: decode table, PCSrc priority, IRQ
// arbitration with stall/kernel/mask gating, exceptions and reset behaviour.
module tb_id_decode_ctrl;

  logic        clk;
  logic        reset;
  logic [5:0]  OpCode;
  logic [5:0]  Funct;
  logic        PC_31;
  logic        PC_id_31;
  logic        BranchEn;
  logic        Stall;
  logic        Flush;
  logic [3:0]  IRQ;
  logic [3:0]  IRQMask;
  logic [2:0]  PCSrc;
  logic        IF_Flush;
  logic [20:0] ex_ctrl;
  logic [3:0]  irq_ack;
  logic [2:0]  irq_cause;
  logic        exc_pending;

  int checks = 0;
  int errors = 0;

  // Hand-built expected bundles (bit 19 valid ... bit 0 Branch).
  localparam logic [31:0] X_ADD  = 32'h000C0080;
  localparam logic [31:0] X_TRAP = 32'h000F3000;
  localparam logic [31:0] X_LW   = 32'h000D9680;
  localparam logic [31:0] X_BUB  = 32'h00000000;

  logic [5:0]  t_op   [9] = '{6'h00, 6'h00, 6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h03, 6'h00};
  logic [5:0]  t_fn   [9] = '{6'h22, 6'h21, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h08};
  logic [31:0] t_ex   [9] = '{32'h000C0082, 32'h000C0000, 32'h000C08C0, 32'h000D9680,
                              32'h00084680, 32'h000802E7, 32'h00080080, 32'h000E2080,
                              32'h00080080};
  logic [2:0]  t_pc   [9] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd2, 3'd2, 3'd3};

  id_decode_ctrl #(.N_IRQ(4), .EN_EXC(1)) dut (
    .clk         (clk),
    .reset       (reset),
    .OpCode      (OpCode),
    .Funct       (Funct),
    .PC_31       (PC_31),
    .PC_id_31    (PC_id_31),
    .BranchEn    (BranchEn),
    .Stall       (Stall),
    .Flush       (Flush),
    .IRQ         (IRQ),
    .IRQMask     (IRQMask),
    .PCSrc       (PCSrc),
    .IF_Flush    (IF_Flush),
    .ex_ctrl     (ex_ctrl),
    .irq_ack     (irq_ack),
    .irq_cause   (irq_cause),
    .exc_pending (exc_pending)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [5:0] op, input logic [5:0] fn);
    OpCode = op;
    Funct  = fn;
  endtask

  initial begin
    reset = 1'b0; PC_31 = 1'b0; PC_id_31 = 1'b0; BranchEn = 1'b0;
    Stall = 1'b0; Flush = 1'b0; IRQ = 4'b0000; IRQMask = 4'b1111;
    set_op(6'h00, 6'h20);
    tick(); tick();

    // Reset state; a jump in ID must not redirect while reset is low.
    set_op(6'h02, 6'h00);
    #1;
    chk("rst_ex_ctrl", 32'(ex_ctrl), X_BUB);
    chk("rst_irq_cause", 32'(irq_cause), 32'd0);
    chk("rst_exc_pending", 32'(exc_pending), 32'd0);
    chk("rst_pcsrc", 32'(PCSrc), 32'd0);
    chk("rst_irq_ack", 32'(irq_ack), 32'd0);

    // add: latency-1 decode.
    reset = 1'b1;
    set_op(6'h00, 6'h20);
    #1;
    chk("add_pcsrc", 32'(PCSrc), 32'd0);
    chk("add_if_flush", 32'(IF_Flush), 32'd0);
    tick();
    chk("add_ex", 32'(ex_ctrl), X_ADD);

    for (int i = 0; i < 9; i++) begin
      set_op(t_op[i], t_fn[i]);
      #1;
      chk($sformatf("dec%0d_pcsrc", i), 32'(PCSrc), 32'(t_pc[i]));
      chk($sformatf("dec%0d_if_flush", i), 32'(IF_Flush), (t_pc[i] != 3'd0) ? 32'd1 : 32'd0);
      tick();
      chk($sformatf("dec%0d_ex", i), 32'(ex_ctrl), t_ex[i]);
    end

    // Branch beats jump; Flush and Flush+Stall load bubbles.
    set_op(6'h00, 6'h20); BranchEn = 1'b1;
    #1;
    chk("br_pcsrc", 32'(PCSrc), 32'd1);
    chk("br_if_flush", 32'(IF_Flush), 32'd1);
    tick();
    chk("br_ex", 32'(ex_ctrl), X_ADD);
    set_op(6'h02, 6'h00);
    #1;
    chk("br_over_j_pcsrc", 32'(PCSrc), 32'd1);
    tick();
    BranchEn = 1'b0; set_op(6'h00, 6'h20); Flush = 1'b1;
    tick();
    chk("flush_ex", 32'(ex_ctrl), X_BUB);
    Stall = 1'b1;
    tick();
    chk("flush_stall_ex", 32'(ex_ctrl), X_BUB);
    Flush = 1'b0; Stall = 1'b0;

    // Two channels: 0 then 1, lowest index first.
    IRQ = 4'b0001;
    #1;
    chk("irq0_edge_cycle_ack", 32'(irq_ack), 32'd0);
    tick();
    IRQ = 4'b0011;
    #1;
    chk("irq0_ack", 32'(irq_ack), 32'b0001);
    chk("irq0_pcsrc", 32'(PCSrc), 32'd4);
    chk("irq0_if_flush", 32'(IF_Flush), 32'd1);
    tick();
    chk("irq0_ex", 32'(ex_ctrl), X_TRAP);
    chk("irq0_cause", 32'(irq_cause), 32'd0);
    chk("irq1_ack", 32'(irq_ack), 32'b0010);
    chk("irq1_pcsrc", 32'(PCSrc), 32'd4);
    tick();
    chk("irq1_cause", 32'(irq_cause), 32'd1);
    chk("irq_idle_ack", 32'(irq_ack), 32'd0);
    chk("irq_idle_pcsrc", 32'(PCSrc), 32'd0);
    tick();
    chk("post_irq_ex", 32'(ex_ctrl), X_ADD);

    // Kernel-mode ID PC blocks the take for three cycles.
    IRQ = 4'b0000;
    tick();
    IRQ = 4'b1000; PC_id_31 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("kmode%0d_ack", i), 32'(irq_ack), 32'd0);
      tick();
    end
    PC_id_31 = 1'b0;
    #1;
    chk("kmode_release_ack", 32'(irq_ack), 32'b1000);
    chk("kmode_release_pcsrc", 32'(PCSrc), 32'd4);
    tick();
    chk("kmode_cause", 32'(irq_cause), 32'd3);

    // Load-use stall: bubble, and the pending IRQ waits for the stall to drop.
    set_op(6'h23, 6'h00); Stall = 1'b1; IRQ = 4'b1010;
    #1;
    chk("stall_edge_ack", 32'(irq_ack), 32'd0);
    tick();
    chk("stall_ex_bubble", 32'(ex_ctrl), X_BUB);
    chk("stall_pending_ack", 32'(irq_ack), 32'd0);
    chk("stall_pcsrc", 32'(PCSrc), 32'd0);
    tick();
    chk("stall_ex_bubble2", 32'(ex_ctrl), X_BUB);
    Stall = 1'b0;
    #1;
    chk("unstall_ack", 32'(irq_ack), 32'b0010);
    chk("unstall_pcsrc", 32'(PCSrc), 32'd4);
    tick();
    chk("unstall_cause", 32'(irq_cause), 32'd1);
    chk("unstall_ex", 32'(ex_ctrl), X_TRAP);
    tick();
    chk("lw_ex", 32'(ex_ctrl), X_LW);

    // Undefined opcode raises an exception; an IRQ in the same cycle wins.
    set_op(6'h3F, 6'h00);
    #1;
    chk("exc_pcsrc", 32'(PCSrc), 32'd5);
    chk("exc_if_flush", 32'(IF_Flush), 32'd1);
    chk("exc_ack", 32'(irq_ack), 32'd0);
    tick();
    chk("exc_pending_set", 32'(exc_pending), 32'd1);
    chk("exc_ex", 32'(ex_ctrl), X_TRAP);
    set_op(6'h00, 6'h20);
    #1;
    chk("exc_clear_pcsrc", 32'(PCSrc), 32'd0);
    tick();
    chk("exc_pending_clr", 32'(exc_pending), 32'd0);
    IRQ = 4'b0000;
    tick();
    IRQ = 4'b0001;
    tick();
    set_op(6'h3F, 6'h00);
    #1;
    chk("exc_irq_pcsrc", 32'(PCSrc), 32'd4);
    chk("exc_irq_ack", 32'(irq_ack), 32'b0001);
    tick();
    chk("exc_irq_no_pending", 32'(exc_pending), 32'd0);
    chk("exc_irq_cause", 32'(irq_cause), 32'd0);

    // Masked channel 2 retained, then taken on unmask.
    set_op(6'h00, 6'h20); IRQ = 4'b0000; IRQMask = 4'b0000;
    tick();
    IRQ = 4'b0100;
    tick();
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("masked%0d_ack", i), 32'(irq_ack), 32'd0);
      tick();
    end
    IRQMask = 4'b0100;
    #1;
    chk("unmask_ack", 32'(irq_ack), 32'b0100);
    chk("unmask_pcsrc", 32'(PCSrc), 32'd4);
    tick();
    chk("unmask_cause", 32'(irq_cause), 32'd2);

    // Reset before unmask discards the pending channel.
    IRQ = 4'b0000; IRQMask = 4'b0000;
    tick();
    IRQ = 4'b0100;
    tick();
    IRQ = 4'b0000;
    tick();
    reset = 1'b0; IRQMask = 4'b0100;
    #1;
    chk("rst_gate_ack", 32'(irq_ack), 32'd0);
    chk("rst_gate_pcsrc", 32'(PCSrc), 32'd0);
    tick();
    chk("rst_mid_cause", 32'(irq_cause), 32'd0);
    chk("rst_mid_ex", 32'(ex_ctrl), X_BUB);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("post_rst%0d_ack", i), 32'(irq_ack), 32'd0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_decode_ctrl.md
ID_DECODE_CTRL -- requirements
Module: id_decode_ctrl

Interface
REQ-001 The block SHALL have parameter N_IRQ, default 4, meaning number of external interrupt channels (1..8).
REQ-002 The block SHALL have parameter EN_EXC, default 1, meaning undefined-instruction exception enabled (0: undefined opcodes decode as NOP).
REQ-003 The block SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 The block SHALL have ports OpCode  input  6 and Funct  input  6  ID-stage instruction fields.
REQ-006 The block SHALL have ports PC_31  input  1 and PC_id_31  input  1  kernel-mode bits of IF and ID PCs.
REQ-007 The block SHALL have port BranchEn  input  1  branch resolved taken.
REQ-008 The block SHALL have ports Stall  input  1 (load-use hazard) and Flush  input  1 (ID squash).
REQ-009 The block SHALL have ports IRQ  input  N_IRQ (level requests) and IRQMask  input  N_IRQ (1 = enabled).
REQ-010 The block SHALL have ports PCSrc  output  3 and IF_Flush  output  1  combinational, current cycle.
REQ-011 The block SHALL have port ex_ctrl  output  21  registered bundle {valid, RegWrite, RegDst[1:0], MemRead, MemWrite, MemtoReg[1:0], ALUSrc1, ALUSrc2, ExtOp, LuOp, Sign, ALUFun[5:0], Branch}.
REQ-012 The block SHALL have ports irq_ack  output  N_IRQ (one-hot pulse), irq_cause  output  3 (registered channel index) and exc_pending  output  1.

Function
REQ-013 Decode SHALL support add, addu, sub, subu, and, or, xor, nor, sll, srl, sra, slt, jr, jalr, lw, sw, lui, addi, addiu, andi, slti, sltiu, beq, bne, blez, bgtz, bltz, j, jal with the team ALUFun/PCSrc encodings.
REQ-014 ex_ctrl SHALL be registered: decode of cycle N appears at cycle N+1 (latency 1).
REQ-015 Stall=1 SHALL load a bubble (valid=0, RegWrite=MemRead=MemWrite=Branch=0) into ex_ctrl and suppress IRQ take and exception raise that cycle.
REQ-016 Flush=1 SHALL load a bubble regardless of decode; Flush has priority over Stall.
REQ-017 Each channel SHALL set its pending bit on a rising edge of IRQ[i] (edge detect by registered previous level); pending persists until taken or reset.
REQ-018 An IRQ SHALL be taken when (pending & IRQMask) != 0, PC_31=0, PC_id_31=0, Stall=0; lowest index wins.
REQ-019 On take: PCSrc=100, IF_Flush=1, ex_ctrl = {valid=1, RegWrite=1, RegDst=11, MemtoReg=11, others 0}, irq_ack[i]=1 for that cycle only, irq_cause<=i next edge, pending[i] cleared next edge.
REQ-020 A new edge on a channel in the same cycle it is taken SHALL re-set its pending bit (set wins over clear).
REQ-021 Undefined opcode/funct with EN_EXC=1 and no IRQ take SHALL drive PCSrc=101, IF_Flush=1, exc_pending=1 next cycle (held until reset or next taken IRQ/exception-free valid decode).
REQ-022 Priority SHALL be IRQ take > exception > BranchEn (001) > j/jal (010) > jr/jalr (011) > sequential (000).
REQ-023 IF_Flush SHALL assert for IRQ take, exception, BranchEn, j, jal, jr, jalr.
REQ-024 Masked pending bits SHALL be retained and taken once unmasked.

Reset
REQ-025 With reset=0 at a rising edge: ex_ctrl=0 (bubble), pending=0, previous-level register=0, irq_cause=0, exc_pending=0.
REQ-026 Reset mid-operation SHALL discard pending IRQs; irq_ack and PCSrc SHALL be 0/000 while reset=0.

Structure
REQ-027 Opcode/funct constants, ALUFun codes, PCSrc encodings and ex_ctrl field offsets SHALL reside in shared package mips_ctrl_pkg.
REQ-028 Edge detection, pending register and priority select SHALL be sub-module irq_arbiter (parameter N_IRQ).

Verification
REQ-029 OpCode=00,Funct=20 (add) -> next cycle ex_ctrl valid=1, RegWrite=1, RegDst=00, ALUFun=00, Sign=1; PCSrc=000.
REQ-030 IRQ=0001→0011 with IRQMask=1111, PC bits 0 -> channel 0 acked first (irq_ack=0001, PCSrc=100), channel 1 next eligible cycle, irq_cause 0 then 1.
REQ-031 IRQ edge while PC_id_31=1 for 3 cycles -> no ack; ack in first cycle PC_id_31=0.
REQ-032 lw in ID with Stall=1 -> ex_ctrl valid=0, MemRead=0; pending IRQ not acked until Stall=0.
REQ-033 OpCode=3F, EN_EXC=1 -> PCSrc=101, IF_Flush=1, exc_pending=1 next cycle; same with simultaneous IRQ -> PCSrc=100.
REQ-034 Pending IRQ on channel 2, IRQMask=0000 for 5 cycles then 0100 -> ack only after unmask; reset=0 before unmask -> no ack ever.
